// File: rtl/change_dispenser.sv
// Change dispenser: takes a price and a payment, then pays out the difference
// greedily (largest affordable coin first), one coin per ready/valid handshake.
module change_dispenser #(
    parameter int unsigned W         = 32'd8,
    parameter int unsigned CNT_W     = 32'd4,
    parameter int unsigned MAX_COINS = 32'd15,
    parameter int unsigned DENOM_HI  = 32'd5,
    parameter int unsigned DENOM_MID = 32'd3,
    parameter int unsigned DENOM_LO  = 32'd1
) (
    input  logic             clock,
    input  logic             reset_L,
    input  logic             start,
    input  logic [W-1:0]     cost,
    input  logic [W-1:0]     paid,
    input  logic             restock,
    input  logic [CNT_W-1:0] restock_hi,
    input  logic [CNT_W-1:0] restock_mid,
    input  logic [CNT_W-1:0] restock_lo,
    output logic             coin_valid,
    input  logic             coin_ready,
    output logic [1:0]       coin,
    output logic             busy,
    output logic             done,
    output logic             exact_amount,
    output logic             cough_up_more,
    output logic             not_enough_change,
    output logic [W-1:0]     remaining,
    output logic [CNT_W-1:0] inv_hi,
    output logic [CNT_W-1:0] inv_mid,
    output logic [CNT_W-1:0] inv_lo
);
    localparam int unsigned     CC_W    = $clog2(MAX_COINS + 32'd1);
    localparam logic [W-1:0]    D_HI    = W'(DENOM_HI);
    localparam logic [W-1:0]    D_MID   = W'(DENOM_MID);
    localparam logic [W-1:0]    D_LO    = W'(DENOM_LO);
    localparam logic [CC_W-1:0] MAX_CNT = CC_W'(MAX_COINS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_DISP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     cost_q, cost_d, paid_q, paid_d, rem_q, rem_d;
    logic [CNT_W-1:0] inv_hi_q, inv_hi_d, inv_mid_q, inv_mid_d, inv_lo_q, inv_lo_d;
    logic [CC_W-1:0]  cnt_q, cnt_d;
    logic             exact_q, exact_d, cum_q, cum_d, nec_q, nec_d;
    logic [1:0]       pick_code_s;
    logic [W-1:0]     pick_val_s;
    logic             offer_s, hs_s;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum[CNT_W]) begin
            return {CNT_W{1'b1}};
        end else begin
            return sum[CNT_W-1:0];
        end
    endfunction

    // Largest coin that fits in the outstanding change and is still in stock.
    always_comb begin
        pick_code_s = 2'd0;
        pick_val_s  = '0;
        if (inv_hi_q != '0 && rem_q >= D_HI) begin
            pick_code_s = 2'd3;
            pick_val_s  = D_HI;
        end else if (inv_mid_q != '0 && rem_q >= D_MID) begin
            pick_code_s = 2'd2;
            pick_val_s  = D_MID;
        end else if (inv_lo_q != '0 && rem_q >= D_LO) begin
            pick_code_s = 2'd1;
            pick_val_s  = D_LO;
        end else begin
            pick_code_s = 2'd0;
            pick_val_s  = '0;
        end
    end

    assign offer_s = (state_q == S_DISP) && (pick_code_s != 2'd0) && (cnt_q < MAX_CNT);
    assign hs_s    = offer_s && coin_ready;

    // State register.
    always_ff @(posedge clock) begin
        if (!reset_L) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = start ? S_EVAL : S_IDLE;
            S_EVAL:  state_d = (paid_q > cost_q) ? S_DISP : S_DONE;
            S_DISP:  state_d = offer_s ? S_DISP : S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath registers: transaction operands, change, inventory, coin count, flags.
    always_ff @(posedge clock) begin
        if (!reset_L) begin
            cost_q    <= '0;
            paid_q    <= '0;
            rem_q     <= '0;
            inv_hi_q  <= '0;
            inv_mid_q <= '0;
            inv_lo_q  <= '0;
            cnt_q     <= '0;
            exact_q   <= 1'b0;
            cum_q     <= 1'b0;
            nec_q     <= 1'b0;
        end else begin
            cost_q    <= cost_d;
            paid_q    <= paid_d;
            rem_q     <= rem_d;
            inv_hi_q  <= inv_hi_d;
            inv_mid_q <= inv_mid_d;
            inv_lo_q  <= inv_lo_d;
            cnt_q     <= cnt_d;
            exact_q   <= exact_d;
            cum_q     <= cum_d;
            nec_q     <= nec_d;
        end
    end

    // Datapath next-state; restock lands before EVAL so a same-cycle start sees it.
    always_comb begin
        cost_d    = cost_q;
        paid_d    = paid_q;
        rem_d     = rem_q;
        inv_hi_d  = inv_hi_q;
        inv_mid_d = inv_mid_q;
        inv_lo_d  = inv_lo_q;
        cnt_d     = cnt_q;
        exact_d   = exact_q;
        cum_d     = cum_q;
        nec_d     = nec_q;
        case (state_q)
            S_IDLE: begin
                if (restock) begin
                    inv_hi_d  = sat_add(inv_hi_q, restock_hi);
                    inv_mid_d = sat_add(inv_mid_q, restock_mid);
                    inv_lo_d  = sat_add(inv_lo_q, restock_lo);
                end else begin
                    inv_hi_d  = inv_hi_q;
                end
                if (start) begin
                    cost_d  = cost;
                    paid_d  = paid;
                    rem_d   = '0;
                    exact_d = 1'b0;
                    cum_d   = 1'b0;
                    nec_d   = 1'b0;
                end else begin
                    cost_d  = cost_q;
                end
            end
            S_EVAL: begin
                exact_d = (paid_q == cost_q) && (paid_q != '0);
                cum_d   = (paid_q < cost_q);
                if (paid_q > cost_q) begin
                    rem_d = paid_q - cost_q;
                    cnt_d = '0;
                end else begin
                    rem_d = '0;
                end
            end
            S_DISP: begin
                if (hs_s) begin
                    rem_d = rem_q - pick_val_s;
                    cnt_d = cnt_q + CC_W'(1'b1);
                    case (pick_code_s)
                        2'd3:    inv_hi_d  = inv_hi_q - {{(CNT_W-1){1'b0}}, 1'b1};
                        2'd2:    inv_mid_d = inv_mid_q - {{(CNT_W-1){1'b0}}, 1'b1};
                        2'd1:    inv_lo_d  = inv_lo_q - {{(CNT_W-1){1'b0}}, 1'b1};
                        default: inv_hi_d  = inv_hi_q;
                    endcase
                end else if (!offer_s) begin
                    nec_d = (paid_q > cost_q) && (rem_q != '0);
                end else begin
                    rem_d = rem_q;
                end
            end
            S_DONE: begin
                nec_d = (paid_q > cost_q) && (rem_q != '0);
            end
            default: begin
                rem_d = rem_q;
            end
        endcase
    end

    // Outputs: the coin offer is a direct function of DISPENSE state so it holds during a stall.
    always_comb begin
        coin_valid        = offer_s;
        coin              = offer_s ? pick_code_s : 2'd0;
        busy              = (state_q != S_IDLE);
        done              = (state_q == S_DONE);
        exact_amount      = exact_q;
        cough_up_more     = cum_q;
        not_enough_change = nec_q;
        remaining         = rem_q;
        inv_hi            = inv_hi_q;
        inv_mid           = inv_mid_q;
        inv_lo            = inv_lo_q;
    end
endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: greedy-change reference model with a per-cycle
// compare process, directed scenarios with literal expectations, random traffic.
`timescale 1ns/1ps
module tb_change_dispenser;
    logic       clock = 1'b0;
    logic       reset_L, start, restock, coin_ready, start2, restock2;
    logic [7:0] cost, paid;
    logic [3:0] restock_hi, restock_mid, restock_lo;
    logic       coin_valid, busy, done, exact_amount, cough_up_more, not_enough_change;
    logic [1:0] coin;
    logic [7:0] remaining;
    logic [3:0] inv_hi, inv_mid, inv_lo;
    logic       coin_valid2, busy2, done2, exact2, cum2, nec2;
    logic [1:0] coin2;
    logic [7:0] remaining2;
    logic [3:0] inv_hi2, inv_mid2, inv_lo2;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    change_dispenser u_dut (
        .clock(clock), .reset_L(reset_L), .start(start), .cost(cost), .paid(paid),
        .restock(restock), .restock_hi(restock_hi), .restock_mid(restock_mid),
        .restock_lo(restock_lo), .coin_valid(coin_valid), .coin_ready(coin_ready),
        .coin(coin), .busy(busy), .done(done), .exact_amount(exact_amount),
        .cough_up_more(cough_up_more), .not_enough_change(not_enough_change),
        .remaining(remaining), .inv_hi(inv_hi), .inv_mid(inv_mid), .inv_lo(inv_lo));

    change_dispenser #(.MAX_COINS(32'd2)) u_dut2 (
        .clock(clock), .reset_L(reset_L), .start(start2), .cost(cost), .paid(paid),
        .restock(restock2), .restock_hi(restock_hi), .restock_mid(restock_mid),
        .restock_lo(restock_lo), .coin_valid(coin_valid2), .coin_ready(coin_ready),
        .coin(coin2), .busy(busy2), .done(done2), .exact_amount(exact2),
        .cough_up_more(cum2), .not_enough_change(nec2),
        .remaining(remaining2), .inv_hi(inv_hi2), .inv_mid(inv_mid2), .inv_lo(inv_lo2));

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    int inv_m[3];
    int exp_q[$];
    int obs[$];
    int exp_rem, exp_lat, held_rem;
    bit exp_exact, exp_cum, exp_nec, held_exact, held_cum, held_nec;
    bit armed = 1'b0, txn_active = 1'b0, was_active;
    int cyc = 0, start_cyc = 0, stalls = 0, last_lat = -1;

    function automatic int sat15(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    function automatic void model_txn(input int c, input int p);
        int den[3];
        int rem, n, k;
        den[0] = 5; den[1] = 3; den[2] = 1;
        exp_q.delete();
        rem = (p > c) ? p - c : 0;
        n   = 0;
        while (p > c && n < 15) begin
            k = -1;
            for (int i = 0; i < 3; i++)
                if (k < 0 && inv_m[i] > 0 && den[i] <= rem) k = i;
            if (k < 0) break;
            rem -= den[k];
            inv_m[k]--;
            n++;
            exp_q.push_back(3 - k);
        end
        exp_rem   = rem;
        exp_exact = (p == c) && (p != 0);
        exp_cum   = (p < c);
        exp_nec   = (p > c) && (rem != 0);
        exp_lat   = (p > c) ? n + 3 : 2;
    endfunction

    // Compare process: checks DUT outputs against the model every cycle, then
    // feeds the model with whatever inputs the next clock edge will sample.
    always @(negedge clock) begin
        if (armed) begin
            cyc++;
            was_active = txn_active;
            chk("busy", busy, txn_active);
            if (!txn_active) begin
                chk("idle_coin_valid", coin_valid, 0);
                chk("idle_coin", coin, 0);
                chk("idle_done", done, 0);
                chk("held_remaining", remaining, held_rem);
                chk("held_exact", exact_amount, held_exact);
                chk("held_cough", cough_up_more, held_cum);
                chk("held_nec", not_enough_change, held_nec);
                chk("inv_hi", inv_hi, inv_m[0]);
                chk("inv_mid", inv_mid, inv_m[1]);
                chk("inv_lo", inv_lo, inv_m[2]);
            end else begin
                if (coin_valid) begin
                    chk("coin", coin, (exp_q.size() > 0) ? exp_q[0] : 0);
                    if (!coin_ready) stalls++;
                    else begin
                        obs.push_back(coin);
                        if (exp_q.size() > 0) void'(exp_q.pop_front());
                    end
                end else begin
                    chk("coin_when_invalid", coin, 0);
                end
                if (done) begin
                    last_lat = cyc - start_cyc;
                    chk("done_latency", last_lat, exp_lat + stalls);
                    chk("coins_left", exp_q.size(), 0);
                    chk("remaining", remaining, exp_rem);
                    chk("exact_amount", exact_amount, exp_exact);
                    chk("cough_up_more", cough_up_more, exp_cum);
                    chk("not_enough_change", not_enough_change, exp_nec);
                    chk("done_inv_hi", inv_hi, inv_m[0]);
                    chk("done_inv_mid", inv_mid, inv_m[1]);
                    chk("done_inv_lo", inv_lo, inv_m[2]);
                    held_rem = exp_rem; held_exact = exp_exact;
                    held_cum = exp_cum; held_nec = exp_nec;
                    txn_active = 1'b0;
                end
            end
        end
        if (!reset_L) begin
            armed = 1'b1;
            txn_active = 1'b0;
            exp_q.delete();
            inv_m[0] = 0; inv_m[1] = 0; inv_m[2] = 0;
            held_rem = 0; held_exact = 1'b0; held_cum = 1'b0; held_nec = 1'b0;
        end else if (armed && !was_active) begin
            if (restock) begin
                inv_m[0] = sat15(inv_m[0] + restock_hi);
                inv_m[1] = sat15(inv_m[1] + restock_mid);
                inv_m[2] = sat15(inv_m[2] + restock_lo);
            end
            if (start) begin
                model_txn(cost, paid);
                txn_active = 1'b1;
                start_cyc = cyc;
                stalls = 0;
                obs.delete();
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        tick();
        reset_L = 1'b1;
    endtask

    task automatic do_restock(input int h, input int m, input int l);
        restock = 1'b1;
        restock_hi = h[3:0]; restock_mid = m[3:0]; restock_lo = l[3:0];
        tick();
        restock = 1'b0;
    endtask

    task automatic run_txn(input int c, input int p, input bit rs,
                           input int h, input int m, input int l, input int pct);
        bit seen;
        start = 1'b1; cost = c[7:0]; paid = p[7:0];
        restock = rs; restock_hi = h[3:0]; restock_mid = m[3:0]; restock_lo = l[3:0];
        coin_ready = ($urandom_range(99) < pct);
        tick();
        start = 1'b0; restock = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            if (done) seen = 1'b1;
            else begin
                coin_ready = ($urandom_range(99) < pct);
                tick();
            end
        end
        if (!seen) chk("done_timeout", 0, 1);
        coin_ready = 1'b1;
        tick();
    endtask

    task automatic chk_obs(input string name, input int idx, input int exp);
        chk(name, (obs.size() > idx) ? obs[idx] : -1, exp);
    endtask

    initial begin
        int log2[$];
        bit seen;
        reset_L = 1'b0; start = 1'b0; restock = 1'b0; coin_ready = 1'b1;
        start2 = 1'b0; restock2 = 1'b0; cost = 8'd0; paid = 8'd0;
        restock_hi = 4'd0; restock_mid = 4'd0; restock_lo = 4'd0;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_inv_hi", inv_hi, 0);
        chk("rst_remaining", remaining, 0);
        chk("rst_flags", {exact_amount, cough_up_more, not_enough_change}, 0);
        reset_L = 1'b1;

        // HI then MID, change exactly covered
        do_restock(2, 2, 2);
        run_txn(3, 11, 1'b0, 0, 0, 0, 100);
        chk("s1_latency", last_lat, 5);
        chk("s1_ncoins", obs.size(), 2);
        chk_obs("s1_coin0", 0, 3);
        chk_obs("s1_coin1", 1, 2);
        chk("s1_remaining", remaining, 0);
        chk("s1_flags", {exact_amount, cough_up_more, not_enough_change}, 0);
        chk("s1_inv", {inv_hi, inv_mid, inv_lo}, {4'd1, 4'd1, 4'd2});

        // Single LO coin, change short
        do_reset();
        do_restock(0, 0, 1);
        run_txn(1, 7, 1'b0, 0, 0, 0, 100);
        chk("s2_ncoins", obs.size(), 1);
        chk_obs("s2_coin0", 0, 1);
        chk("s2_remaining", remaining, 5);
        chk("s2_nec", not_enough_change, 1);

        // Underpaid / exact / zero
        run_txn(9, 4, 1'b0, 0, 0, 0, 100);
        chk("s3_cough", cough_up_more, 1);
        chk("s3_latency", last_lat, 2);
        chk("s3_ncoins", obs.size(), 0);
        run_txn(6, 6, 1'b0, 0, 0, 0, 100);
        chk("s3_exact", exact_amount, 1);
        chk("s3_cough_clr", cough_up_more, 0);
        run_txn(0, 0, 1'b0, 0, 0, 0, 100);
        chk("s3_zero_flags", {exact_amount, cough_up_more, not_enough_change}, 0);

        // Same-cycle restock+start, 3-cycle stall on the first offer
        do_reset();
        start = 1'b1; cost = 8'd0; paid = 8'd9; coin_ready = 1'b0;
        restock = 1'b1; restock_hi = 4'd1; restock_mid = 4'd1; restock_lo = 4'd1;
        tick();
        start = 1'b0; restock = 1'b0;
        for (int k = 0; k < 20 && !coin_valid; k++) tick();
        repeat (3) tick();
        coin_ready = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (done) seen = 1'b1;
            else tick();
        end
        if (!seen) chk("s4_done_timeout", 0, 1);
        tick();
        chk("s4_latency", last_lat, 9);
        chk("s4_ncoins", obs.size(), 3);
        chk_obs("s4_coin0", 0, 3);
        chk_obs("s4_coin1", 1, 2);
        chk_obs("s4_coin2", 2, 1);
        chk("s4_remaining", remaining, 0);

        // Saturation, and coin cap on the MAX_COINS=2 instance
        do_reset();
        restock2 = 1'b1;
        do_restock(15, 15, 15);
        restock2 = 1'b1;
        do_restock(15, 15, 15);
        restock2 = 1'b0;
        chk("s5_inv_sat", {inv_hi, inv_mid, inv_lo}, {4'd15, 4'd15, 4'd15});
        chk("s5_inv2_sat", {inv_hi2, inv_mid2, inv_lo2}, {4'd15, 4'd15, 4'd15});
        start2 = 1'b1; cost = 8'd0; paid = 8'd15; coin_ready = 1'b1;
        tick();
        start2 = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (coin_valid2) log2.push_back(coin2);
            if (done2) seen = 1'b1;
            else tick();
        end
        if (!seen) chk("s5_done_timeout", 0, 1);
        chk("s5_ncoins", log2.size(), 2);
        chk("s5_coins", (log2.size() == 2) ? log2[0] * 4 + log2[1] : -1, 15);
        chk("s5_remaining2", remaining2, 5);
        chk("s5_nec2", nec2, 1);
        chk("s5_inv2_hi", inv_hi2, 13);
        tick();

        // Reset in the middle of a stalled dispense
        do_restock(1, 1, 1);
        start = 1'b1; cost = 8'd0; paid = 8'd9; coin_ready = 1'b0;
        tick();
        start = 1'b0;
        for (int k = 0; k < 20 && !coin_valid; k++) tick();
        chk("s6_offer", coin_valid, 1);
        tick(); tick();
        reset_L = 1'b0;
        tick();
        reset_L = 1'b1;
        chk("s6_busy", busy, 0);
        chk("s6_outputs", {coin_valid, coin, done, exact_amount, cough_up_more,
                            not_enough_change}, 0);
        chk("s6_rem_inv", {remaining, inv_hi, inv_mid, inv_lo}, 0);
        for (int k = 0; k < 4; k++) begin
            chk("s6_no_done", done, 0);
            tick();
        end

        // Random traffic
        for (int t = 0; t < 150; t++) begin
            int c, p, pct;
            c = $urandom_range(30);
            p = $urandom_range(45);
            pct = $urandom_range(100, 30);
            if ($urandom_range(9) == 0) p = c;
            if ($urandom_range(2) == 0)
                do_restock($urandom_range(5), $urandom_range(5), $urandom_range(6));
            if ($urandom_range(14) == 0) begin
                start = 1'b1; cost = c[7:0]; paid = p[7:0];
                tick();
                start = 1'b0;
                repeat ($urandom_range(6, 1)) begin
                    coin_ready = ($urandom_range(99) < pct);
                    tick();
                end
                do_reset();
                coin_ready = 1'b1;
            end else begin
                run_txn(c, p, $urandom_range(3) == 0, $urandom_range(3),
                        $urandom_range(3), $urandom_range(3), pct);
            end
        end
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
